// File: rtl/lcd_bus_if.sv
//------------------------------------------------------------------------------
// lcd_bus_if
// The 8-bit parallel ST7920-style LCD bus as the display controller drives it.
//   rs   : register select, 0 = command, 1 = data
//   rw   : read/write, 0 = write
//   en   : enable, a transfer is taken on its falling edge
//   data : 8-bit bus data
// Modports: master drives the bus (display controller / bench), slave only
// observes it (lcd_bus_receiver never drives the data lines).
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface lcd_bus_if;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] data;

  modport master (output rs, rw, en, data);
  modport slave  (input  rs, rw, en, data);
endinterface

// File: rtl/lcd_bus_receiver.sv
//------------------------------------------------------------------------------
// lcd_bus_receiver
// Mirror/loopback receiver for the ST7920-style LCD bus. Synchronises the bus
// into the clk domain, decodes basic/extended instructions and the GDRAM Y/X
// address pair, and turns every graphics data byte into a one-cycle write on a
// 1024-byte frame-buffer port.
//
// Optional feature macro: LCD_RX_CLEAR_EN
//   defined   : command 0x01 in BASIC fills the frame buffer with CLR_VAL
//               (1024 consecutive writes, busy high meanwhile)
//   undefined : 0x01 is an ordinary accepted command, busy tied to 0
//
// Ports:
//   clk          50 MHz system clock
//   rst          asynchronous, active-low reset
//   bus          lcd_bus_if.slave (rs, rw, en, data; asynchronous to clk)
//   fb_we_o      frame-buffer write strobe, one clk wide
//   fb_addr_o    frame-buffer address {half, y[4:0], byte[3:0]}
//   fb_wdata_o   frame-buffer write data
//   cmd_valid_o  one-clk pulse per accepted command byte
//   cmd_byte_o   last accepted command byte, held
//   ext_mode_o   RE bit (function set)
//   graphic_on_o G bit (extended function set)
//   disp_on_o    D bit (display control)
//   frame_done_o one-clk pulse with the write to address 1023
//   err_o        one-clk pulse when a strobe is dropped
//   busy_o       clear sequence in progress
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module lcd_bus_receiver #(
  parameter logic [7:0] CLR_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  lcd_bus_if.slave   bus,
  output logic       fb_we_o,
  output logic [9:0] fb_addr_o,
  output logic [7:0] fb_wdata_o,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_byte_o,
  output logic       ext_mode_o,
  output logic       graphic_on_o,
  output logic       disp_on_o,
  output logic       frame_done_o,
  output logic       err_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_BASIC = 2'd0,
    ST_EXT   = 2'd1,
    ST_XWAIT = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  // Synchroniser: every bus line gets the same 2-FF depth so rs/rw/data at
  // stage 2 line up with en at stage 2; the extra en stage detects the fall.
  logic       rs_s1_q, rs_s2_q;
  logic       rw_s1_q, rw_s2_q;
  logic       en_s1_q, en_s2_q, en_s3_q;
  logic [7:0] data_s1_q, data_s2_q;
  logic       strobe;

  // Stages start low so an idle-low en after reset never looks like a fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_s1_q   <= 1'b0;
      rs_s2_q   <= 1'b0;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
      en_s3_q   <= 1'b0;
      data_s1_q <= 8'h00;
      data_s2_q <= 8'h00;
    end else begin
      rs_s1_q   <= bus.rs;
      rs_s2_q   <= rs_s1_q;
      rw_s1_q   <= bus.rw;
      rw_s2_q   <= rw_s1_q;
      en_s1_q   <= bus.en;
      en_s2_q   <= en_s1_q;
      en_s3_q   <= en_s2_q;
      data_s1_q <= bus.data;
      data_s2_q <= data_s1_q;
    end
  end

  assign strobe = en_s3_q & ~en_s2_q;

  state_t     state_q, state_d;
  logic       ext_q, ext_d;
  logic       gfx_q, gfx_d;
  logic       disp_q, disp_d;
  logic       addr_valid_q, addr_valid_d;
  logic       half_q, half_d;
  logic [4:0] y_q, y_d;
  logic [2:0] x_q, x_d;
  logic       tog_q, tog_d;
  logic       fb_we_q, fb_we_d;
  logic [9:0] fb_addr_q, fb_addr_d;
  logic [7:0] fb_wdata_q, fb_wdata_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic       frame_done_q, frame_done_d;
  logic       err_q, err_d;
  logic [9:0] wr_addr;
`ifdef LCD_RX_CLEAR_EN
  logic       busy_q, busy_d;
  logic [9:0] clr_cnt_q, clr_cnt_d;
`endif

  assign wr_addr = {half_q, y_q, x_q, tog_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BASIC;
      ext_q        <= 1'b0;
      gfx_q        <= 1'b0;
      disp_q       <= 1'b0;
      addr_valid_q <= 1'b0;
      half_q       <= 1'b0;
      y_q          <= 5'd0;
      x_q          <= 3'd0;
      tog_q        <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= 10'd0;
      fb_wdata_q   <= 8'h00;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= 8'h00;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef LCD_RX_CLEAR_EN
      busy_q       <= 1'b0;
      clr_cnt_q    <= 10'd0;
`endif
    end else begin
      state_q      <= state_d;
      ext_q        <= ext_d;
      gfx_q        <= gfx_d;
      disp_q       <= disp_d;
      addr_valid_q <= addr_valid_d;
      half_q       <= half_d;
      y_q          <= y_d;
      x_q          <= x_d;
      tog_q        <= tog_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
`ifdef LCD_RX_CLEAR_EN
      busy_q       <= busy_d;
      clr_cnt_q    <= clr_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    ext_d        = ext_q;
    gfx_d        = gfx_q;
    disp_d       = disp_q;
    addr_valid_d = addr_valid_q;
    half_d       = half_q;
    y_d          = y_q;
    x_d          = x_q;
    tog_d        = tog_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    cmd_valid_d  = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
`ifdef LCD_RX_CLEAR_EN
    busy_d       = busy_q;
    clr_cnt_d    = clr_cnt_q;
`endif

    if (state_q == ST_CLEAR) begin
`ifdef LCD_RX_CLEAR_EN
      // Address 0 is written on entry; the counter wrapping back to 0 means
      // all 1024 locations have been issued and the sequence is over.
      if (strobe) err_d = 1'b1;
      if (clr_cnt_q == 10'd0) begin
        state_d      = ST_BASIC;
        busy_d       = 1'b0;
        addr_valid_d = 1'b0;
        half_d       = 1'b0;
        y_d          = 5'd0;
        x_d          = 3'd0;
        tog_d        = 1'b0;
      end else begin
        fb_we_d      = 1'b1;
        fb_addr_d    = clr_cnt_q;
        fb_wdata_d   = CLR_VAL;
        frame_done_d = (clr_cnt_q == 10'h3FF);
        clr_cnt_d    = clr_cnt_q + 10'd1;
      end
`else
      state_d = ST_BASIC;
`endif
    end else if (strobe) begin
      if (rw_s2_q) begin
        err_d = 1'b1;
      end else if (!rs_s2_q) begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = data_s2_q;
        // Function set wins over every state-specific decode, XWAIT included.
        if (data_s2_q[5]) begin
          ext_d = data_s2_q[2];
          if (data_s2_q[2]) begin
            gfx_d   = data_s2_q[1];
            state_d = ST_EXT;
          end else begin
            state_d = ST_BASIC;
          end
        end else begin
          case (state_q)
            ST_BASIC: begin
              if (data_s2_q[7:3] == 5'b00001) begin
                disp_d = data_s2_q[2];
              end
`ifdef LCD_RX_CLEAR_EN
              else if (data_s2_q == 8'h01) begin
                state_d    = ST_CLEAR;
                busy_d     = 1'b1;
                fb_we_d    = 1'b1;
                fb_addr_d  = 10'd0;
                fb_wdata_d = CLR_VAL;
                clr_cnt_d  = 10'd1;
              end
`endif
            end
            ST_EXT: begin
              if (data_s2_q[7]) begin
                y_d     = data_s2_q[4:0];
                state_d = ST_XWAIT;
              end
            end
            ST_XWAIT: begin
              if (data_s2_q[7]) begin
                half_d       = data_s2_q[3];
                x_d          = data_s2_q[2:0];
                tog_d        = 1'b0;
                addr_valid_d = 1'b1;
                state_d      = ST_EXT;
              end
            end
            default: ;
          endcase
        end
      end else if (addr_valid_q && (state_q != ST_XWAIT)) begin
        // Two bytes per 16-bit GDRAM word: tog selects the byte, x advances
        // after the second byte and wraps within the row.
        fb_we_d      = 1'b1;
        fb_addr_d    = wr_addr;
        fb_wdata_d   = data_s2_q;
        frame_done_d = &wr_addr;
        tog_d        = ~tog_q;
        if (tog_q) x_d = x_q + 3'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign fb_we_o      = fb_we_q;
  assign fb_addr_o    = fb_addr_q;
  assign fb_wdata_o   = fb_wdata_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_byte_o   = cmd_byte_q;
  assign ext_mode_o   = ext_q;
  assign graphic_on_o = gfx_q;
  assign disp_on_o    = disp_q;
  assign frame_done_o = frame_done_q;
  assign err_o        = err_q;
`ifdef LCD_RX_CLEAR_EN
  assign busy_o       = busy_q;
`else
  assign busy_o       = 1'b0;
`endif

endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Receiving end of the 8-bit parallel ST7920-style LCD bus (rs, rw, en, data) driven by our LCD display controllers. It samples the bus in the 50 MHz domain and decodes basic and extended instructions, including the GDRAM Y/X address pair. Each graphics data byte becomes a single-cycle write into a 1024-byte frame-buffer port. It sits on the FPGA alongside the display controller as a loopback/mirror target, for VGA mirroring and in-system checking of what was sent to the panel.

## Interface
- CLR_VAL, 8'h00, byte written to every frame-buffer location by the clear-display sequence
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-low reset
- rs  in  1  bus register select, 0 = command, 1 = data (asynchronous to clk)
- rw  in  1  bus read/write, 0 = write (asynchronous)
- en  in  1  bus enable; a transfer is taken on its falling edge (asynchronous)
- data  in  8  bus data (asynchronous)
- fb_we  out  1  frame-buffer write strobe, one clk wide
- fb_addr  out  10  {half, y[4:0], byte[3:0]}
- fb_wdata  out  8  frame-buffer write data
- cmd_valid  out  1  one-clk pulse per accepted command byte
- cmd_byte  out  8  last command byte, held
- ext_mode  out  1  RE bit from function set
- graphic_on  out  1  G bit from extended function set
- disp_on  out  1  D bit from display control
- frame_done  out  1  one-clk pulse on the write to fb_addr 1023
- err  out  1  one-clk pulse when a strobe is dropped
- busy  out  1  clear sequence in progress (0 unless LCD_RX_CLEAR_EN)

## Operation
- rs, rw, en and data each pass through a 2-FF synchronizer into an identical-depth pipeline, plus a third en stage. A strobe is en_s3 & ~en_s2; rs and data are taken from stage 2.
- A strobe with rw=1 is a read. It is ignored and err pulses. The bus data lines are never driven.
- States: BASIC (RE=0), EXT (RE=1), XWAIT (Y set, waiting for X), CLEAR (macro only).
- Command 0011_x0xx (any state) sets RE=0 and moves to BASIC.
- Command 0011_x1xx (any state) sets RE=1, G=data[1] and moves to EXT.
- In BASIC:
  - 0000_1DCB sets disp_on=D.
  - 0000_01xx is accepted (entry mode) with no other effect.
  - 0000_0001 is clear display.
  - Any other command is accepted with no effect.
- In EXT, command 1xxx_xxxx latches y=data[4:0] and moves to XWAIT.
- In XWAIT, command 1xxx_xxxx latches half=data[3], x=data[2:0], clears the byte toggle, sets addr_valid and returns to EXT.
- A rs=0 write with data[5]=1 (function set) is always decoded as function set, including in XWAIT.
- Every accepted command:
  - pulses cmd_valid;
  - updates cmd_byte.
- Data write (rs=1) while addr_valid=1 and state EXT or BASIC:
  - fb_we=1, fb_addr={half, y, x, tog}, fb_wdata=data.
  - Then tog toggles. When tog goes 1 to 0, x increments modulo 8; y and half are unchanged.
- Data write while addr_valid=0 or in XWAIT: dropped, err pulses.
- frame_done pulses together with fb_we when fb_addr==10'h3FF.

## Timing
- Edge 1 is the first clk edge that samples en low. The strobe is decoded after edge 2. fb_we, cmd_valid, frame_done and err are high from edge 3 to edge 4. Status outputs update at edge 3.
- Minimum en low and high width: 3 clk each. Narrower pulses may be missed.
- Reset values: fb_we, cmd_valid, frame_done, err, busy = 0; fb_addr = 0; fb_wdata = 0; cmd_byte = 8'h00; ext_mode, graphic_on, disp_on = 0; state BASIC; addr_valid = 0; x, y, half, tog = 0.
- Reset mid-clear aborts immediately: busy=0, fb_we=0.

## Configuration
- LCD_RX_CLEAR_EN defined:
  - Command 0x01 in BASIC enters CLEAR. busy=1 from edge 3.
  - fb_we=1 with fb_wdata=CLR_VAL for 1024 consecutive clks, fb_addr 0 to 1023. frame_done pulses on the last write.
  - Then busy=0 and the state returns to BASIC. x, y, half, tog and addr_valid are cleared.
  - Any strobe during CLEAR is dropped with an err pulse.
- Not defined: 0x01 is accepted like any other BASIC command, with no frame-buffer activity. busy is tied to 0.

## Test plan
- Write 0x30, 0x06, 0x0C, 0x36 → four cmd_valid pulses, disp_on=1, ext_mode=1, graphic_on=1, no fb_we.
- Write 0x85, 0x8B, then data 0xAA, 0x55, 0xFF → fb_addr 0x256, 0x257, 0x258 with the matching data; frame_done stays 0.
- Write 0x9F, 0x8F, then data ×3 → fb_addr 0x3FE, 0x3FF (frame_done pulse), then 0x3F0 (x wraps 7→0).
- After reset, data 0x12; then 0x36, 0x80, data 0x34 → err pulse on both data bytes, no fb_we; then 0x80 → next data 0x56 writes fb_addr 0x000.
- Strobe with rw=1, data 0xC3 → err pulse, no cmd_valid, no fb_we.
- With LCD_RX_CLEAR_EN: 0x30, 0x01 → busy=1 for 1024 clks, 1024 fb_we with data 0x00, frame_done at 0x3FF. A data strobe mid-clear gives an err pulse. Reset mid-clear gives busy=0 immediately.
